// File: rtl/fdtd_ez_writeback.sv
// fdtd_ez_writeback
// Write-back stage behind the Ez update datapath. Each cell issued into the
// datapath is followed through its fixed latency by a one-bit valid pipe.
// The Ez result is captured when it emerges and passed through the PEC
// boundary and soft-source rules. The final value is written into the Ez
// field RAM, and the end of the time step is reported to the controller.

module fdtd_ez_writeback #(
   parameter int FDTD_DATA_WIDTH = 32,
   parameter int ADDR_WIDTH      = 10,
   parameter int NUM_CELLS       = 200,
   parameter int LATENCY         = 4,
   parameter int SRC_IDX         = 100
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              clken,
   input  logic                              start_i,
   input  logic                              issue_i,
   input  logic signed [FDTD_DATA_WIDTH-1:0] ez_i,
   input  logic signed [FDTD_DATA_WIDTH-1:0] src_val_i,
   output logic                              wr_en_o,
   output logic        [ADDR_WIDTH-1:0]      wr_addr_o,
   output logic signed [FDTD_DATA_WIDTH-1:0] wr_data_o,
   output logic                              busy_o,
   output logic                              done_o,
   output logic                              overflow_o
);

   localparam int W     = FDTD_DATA_WIDTH;
   // The issue counter must be able to hold NUM_CELLS itself, so that it can
   // tell "all cells issued" apart from the last cell.
   localparam int CNT_W = $clog2(NUM_CELLS + 1);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_CELLS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CELLS - 1);
   localparam logic [CNT_W-1:0] CNT_SRC  = CNT_W'(SRC_IDX);

   localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0]    iss_cnt;
   logic [CNT_W-1:0]    wr_cnt;
   logic [LATENCY-1:0]  vld_sr;
   logic signed [W-1:0] src_q;

   logic                start_acc;
   logic                issue_acc;
   logic                issue_ovf;
   logic                capture;
   logic                last_wr;
   logic signed [W:0]   sum_ext;
   logic signed [W-1:0] sat_sum;
   logic signed [W-1:0] data_nxt;

   // Qualify the raw strobes against the current state and the counters.
   always_comb begin
      start_acc = (state == S_IDLE) && start_i;
      // A cell enters the valid pipe only while a step runs and room is left.
      issue_acc = issue_i && clken && (state == S_RUN) && (iss_cnt < CNT_FULL);
      issue_ovf = issue_i && clken && (state == S_RUN) && (iss_cnt >= CNT_FULL);
      // A result is taken only on an enabled cycle, when the pipe tail is valid.
      capture   = vld_sr[LATENCY-1] && clken && (state == S_RUN);
      last_wr   = capture && (wr_cnt == CNT_LAST);
   end

   // Next-state logic of the step sequencer.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_next = state;
      case (state)
         S_IDLE:  if (start_i) state_next = S_RUN;
         S_RUN:   if (last_wr) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register of the step sequencer.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: registers are updated with non-blocking assignments, so every
      // flop samples the values from before the edge, whatever the order of
      // the statements.
      if (RST) state <= S_IDLE;
      else     state <= state_next;
   end

   // Saturating add of the Ez result and the latched source sample.
   always_comb begin
      sum_ext = {ez_i[W-1], ez_i} + {src_q[W-1], src_q};
      sat_sum = sum_ext[W-1:0];
      // The two top bits of the widened sum differ only on signed overflow.
      if (sum_ext[W] != sum_ext[W-1]) begin
         sat_sum = sum_ext[W] ? SAT_MIN : SAT_MAX;
      end
   end

   // Choose the value written for the current cell: PEC, source or pass-through.
   always_comb begin
      data_nxt = ez_i;
      if ((wr_cnt == '0) || (wr_cnt == CNT_LAST)) begin
         data_nxt = '0;
      end else if (wr_cnt == CNT_SRC) begin
         data_nxt = sat_sum;
      end
   end

   // Step bookkeeping: issue and write counters, source latch, sticky overflow.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         iss_cnt    <= '0;
         wr_cnt     <= '0;
         src_q      <= '0;
         overflow_o <= 1'b0;
      end else if (start_acc) begin
         iss_cnt    <= '0;
         wr_cnt     <= '0;
         src_q      <= src_val_i;
         overflow_o <= 1'b0;
      end else begin
         if (issue_acc) iss_cnt    <= iss_cnt + 1'b1;
         if (issue_ovf) overflow_o <= 1'b1;
         if (capture)   wr_cnt     <= wr_cnt + 1'b1;
      end
   end

   // Valid pipe that mirrors the datapath latency and stalls with it.
   always_ff @(posedge CLK or posedge RST) begin
      // NOTE: this shift register is only LATENCY flops of control state, so
      // it is reset. That way a reset in the middle of a step cannot later
      // release stale valid bits.
      if (RST) begin
         vld_sr <= '0;
      end else if (clken) begin
         vld_sr[0] <= issue_acc;
         for (int i = 1; i < LATENCY; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
      end
   end

   // Registered field RAM write port.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wr_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
      end else begin
         wr_en_o <= capture;
         if (capture) begin
            wr_addr_o <= ADDR_WIDTH'(wr_cnt);
            wr_data_o <= data_nxt;
         end
      end
   end

   // Status to the controller. Busy covers the last write; done follows it.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         busy_o <= 1'b0;
         done_o <= 1'b0;
      end else begin
         busy_o <= (state_next != S_IDLE);
         done_o <= (state == S_DONE);
      end
   end

endmodule
